// File: rtl/mv_operand_loader_if.sv
// Byte-stream handshake carrying operands into the matrix-vector operand loader.
// The master drives data/valid/last; the slave (loader) returns ready.
interface mv_operand_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/mv_operand_loader.sv
// Serial-to-parallel operand loader for the 3x3 matrix-vector multiplier.
// Stages 11 bytes in shadow registers and commits all 12 operands (the 12th
// straight from the bus) in a single edge, so downstream never sees a mix of
// old and new operands. Frames of the wrong length raise a sticky error.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_LOAD   | accepting beats of a frame into shadow[idx]
//   S_COMMIT | one-cycle bubble after commit; op_valid high, in_ready low
//   S_DRAIN  | long frame detected; discarding beats up to and incl. in_last
module mv_operand_loader #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  mv_operand_loader_if.slave stream,
  input  logic              err_clr,
  output logic [DATA_W-1:0] matrix00,
  output logic [DATA_W-1:0] matrix01,
  output logic [DATA_W-1:0] matrix02,
  output logic [DATA_W-1:0] matrix10,
  output logic [DATA_W-1:0] matrix11,
  output logic [DATA_W-1:0] matrix12,
  output logic [DATA_W-1:0] matrix20,
  output logic [DATA_W-1:0] matrix21,
  output logic [DATA_W-1:0] matrix22,
  output logic [DATA_W-1:0] vector_0,
  output logic [DATA_W-1:0] vector_1,
  output logic [DATA_W-1:0] vector_2,
  output logic              op_valid,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_COMMIT = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd11;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        idx;
  logic [DATA_W-1:0] shadow [0:10];
  logic [DATA_W-1:0] ops    [0:11];

  logic ready;
  logic beat;
  logic at_end;
  logic shadow_wr;
  logic idx_inc;
  logic idx_clr;
  logic commit;
  logic err_set;

  // Ready depends only on state and reset, keeping in_valid out of the ready path.
  assign ready           = !rst && (state != S_COMMIT);
  assign stream.in_ready = ready;
  assign beat            = stream.in_valid && ready;
  assign at_end          = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (beat && at_end) begin
          state_nxt = stream.in_last ? S_COMMIT : S_DRAIN;
        end
      end
      S_COMMIT: state_nxt = S_LOAD;
      S_DRAIN: begin
        if (beat && stream.in_last) begin
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Output and datapath-strobe decode.
  always_comb begin
    op_valid  = 1'b0;
    shadow_wr = 1'b0;
    idx_inc   = 1'b0;
    idx_clr   = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_LOAD: begin
        if (beat) begin
          if (!at_end) begin
            if (stream.in_last) begin
              // Short frame: drop it, shadow contents left as-is.
              err_set = 1'b1;
              idx_clr = 1'b1;
            end else begin
              shadow_wr = 1'b1;
              idx_inc   = 1'b1;
            end
          end else begin
            idx_clr = 1'b1;
            if (stream.in_last) begin
              commit = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end
      end
      S_COMMIT: op_valid = 1'b1;
      S_DRAIN:  ;
      default:  ;
    endcase
  end

  // Beat index: advances per staged beat, returns to 0 on frame end or error.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (idx_clr) begin
      idx <= '0;
    end else if (idx_inc) begin
      idx <= idx + 4'd1;
    end
  end

  // Shadow registers for beats 0..10.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        shadow[i] <= '0;
      end
    end else if (shadow_wr) begin
      shadow[idx] <= stream.in_data;
    end
  end

  // Committed operands: all twelve update together, v2 taken from the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) begin
        ops[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < 11; i++) begin
        ops[i] <= shadow[i];
      end
      ops[11] <= stream.in_data;
    end
  end

  // Committed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (commit) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Sticky framing error; a new error on the clear edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (err_set) begin
      frame_err <= 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
    end
  end

  assign matrix00 = ops[0];
  assign matrix01 = ops[1];
  assign matrix02 = ops[2];
  assign matrix10 = ops[3];
  assign matrix11 = ops[4];
  assign matrix12 = ops[5];
  assign matrix20 = ops[6];
  assign matrix21 = ops[7];
  assign matrix22 = ops[8];
  assign vector_0 = ops[9];
  assign vector_1 = ops[10];
  assign vector_2 = ops[11];

endmodule

// File: tb/tb_mv_operand_loader.sv
// Scoreboard bench for mv_operand_loader: the driver feeds frames and a
// frame-level model pushes expected operand sets; a monitor pops on op_valid.
module tb_mv_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic [7:0]  matrix00, matrix01, matrix02, matrix10, matrix11, matrix12;
  logic [7:0]  matrix20, matrix21, matrix22, vector_0, vector_1, vector_2;
  logic        op_valid;
  logic        frame_err;
  logic [15:0] frame_cnt;

  mv_operand_loader_if #(.DATA_W(8)) bus ();

  mv_operand_loader #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .stream    (bus),
    .err_clr   (err_clr),
    .matrix00  (matrix00),
    .matrix01  (matrix01),
    .matrix02  (matrix02),
    .matrix10  (matrix10),
    .matrix11  (matrix11),
    .matrix12  (matrix12),
    .matrix20  (matrix20),
    .matrix21  (matrix21),
    .matrix22  (matrix22),
    .vector_0  (vector_0),
    .vector_1  (vector_1),
    .vector_2  (vector_2),
    .op_valid  (op_valid),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  cur[$];        // bytes accepted in the current frame
  logic [95:0] exp_q[$];      // committed operand sets awaiting op_valid
  logic [95:0] exp_hold = '0; // operand set the outputs must show
  logic [15:0] exp_cnt  = '0;
  logic        exp_err  = 1'b0;
  bit          mon_en   = 1'b0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [95:0] pack12();
    logic [95:0] p = '0;
    for (int i = 0; i < 12; i++) p[95-8*i -: 8] = cur[i];
    return p;
  endfunction

  // Frame-level rule: only a frame of exactly 12 beats commits; a frame ending
  // early errors at its last beat, a frame running long errors at beat 12.
  task automatic post_edge(input bit ok, input logic [7:0] b, input bit last, input bit clr);
    bit set = 1'b0;
    if (ok) begin
      cur.push_back(b);
      if (last) begin
        if (cur.size() == 12) begin
          exp_q.push_back(pack12());
          exp_cnt = exp_cnt + 16'd1;
        end else if (cur.size() < 12) begin
          set = 1'b1;
        end
        cur.delete();
      end else if (cur.size() == 12) begin
        set = 1'b1;
      end
    end
    if (set) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      err_clr      = clr;
      @(posedge clk); #1;
      post_edge(1'b0, 8'h00, 1'b0, clr);
    end
    err_clr = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] b, input bit last, input bit clr_in);
    bit ok;
    bit clr = clr_in;
    int guard = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    forever begin
      err_clr = clr;
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      post_edge(ok, b, last, clr);
      clr = 1'b0;
      err_clr = 1'b0;
      if (ok) break;
      guard++;
      if (guard > 40) begin
        check("ready_timeout", 128'(0), 128'(1));
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_list(input logic [7:0] fr[$], input bit last_at_end,
                           input int gap_a, input int gap_b, input int gap_pct,
                           input bit clr_last);
    for (int i = 0; i < fr.size(); i++) begin
      bit lst = last_at_end && (i == fr.size() - 1);
      if (gap_pct > 0 && ($urandom % 100) < gap_pct) idle($urandom_range(1, 3), 1'b0);
      drive_beat(fr[i], lst, clr_last && lst);
      if (i + 1 == gap_a || i + 1 == gap_b) idle(3, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
    @(posedge clk); #1;
    cur.delete();
    exp_q.delete();
    exp_hold = '0;
    exp_cnt  = '0;
    exp_err  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [95:0] outs();
    return {matrix00, matrix01, matrix02, matrix10, matrix11, matrix12,
            matrix20, matrix21, matrix22, vector_0, vector_1, vector_2};
  endfunction

  // Monitor: pops on op_valid and checks held outputs, counter and flag every cycle.
  initial begin
    bit prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) check("ready_in_reset", 128'(bus.in_ready), 128'(0));
        if (op_valid) begin
          check("op_valid_width", 128'(prev_ov), 128'(0));
          check("ready_in_commit", 128'(bus.in_ready), 128'(0));
          if (exp_q.size() == 0) check("unexpected_commit", 128'(1), 128'(0));
          else exp_hold = exp_q.pop_front();
        end else if (exp_q.size() != 0) begin
          check("missing_op_valid", 128'(0), 128'(1));
          exp_hold = exp_q.pop_front();
        end
        check("operands", 128'(outs()), 128'(exp_hold));
        check("frame_cnt", 128'(frame_cnt), 128'(exp_cnt));
        check("frame_err", 128'(frame_err), 128'(exp_err));
        prev_ov = op_valid;
      end
    end
  end

  initial begin
    logic [7:0] fr[$];
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    do_reset();
    mon_en = 1'b1;
    check("reset_operands", 128'(outs()), 128'(0));
    check("reset_cnt", 128'(frame_cnt), 128'(0));
    check("reset_op_valid", 128'(op_valid), 128'(0));

    // Back-to-back 1..12
    fr.delete();
    for (int i = 1; i <= 12; i++) fr.push_back(8'(i));
    send_list(fr, 1'b1, 0, 0, 0, 1'b0);
    idle(1, 1'b0);
    check("t1_m00", 128'(matrix00), 128'(1));
    check("t1_m22", 128'(matrix22), 128'(9));
    check("t1_v2", 128'(vector_2), 128'(12));
    check("t1_cnt", 128'(frame_cnt), 128'(1));

    // Same frame with gaps after beats 5 and 11
    send_list(fr, 1'b1, 5, 11, 0, 1'b0);
    idle(1, 1'b0);
    check("t2_v0", 128'(vector_0), 128'(10));
    check("t2_cnt", 128'(frame_cnt), 128'(2));

    // Short frame then good frame
    fr.delete();
    for (int i = 0; i < 7; i++) fr.push_back(8'hAA);
    send_list(fr, 1'b1, 0, 0, 0, 1'b0);
    idle(2, 1'b0);
    check("t3_err", 128'(frame_err), 128'(1));
    check("t3_unchanged", 128'(matrix00), 128'(1));
    fr.delete();
    for (int i = 1; i <= 12; i++) fr.push_back(8'(i));
    send_list(fr, 1'b1, 0, 0, 0, 1'b0);
    idle(1, 1'b0);
    check("t3_cnt", 128'(frame_cnt), 128'(3));

    // err_clr while idle
    idle(1, 1'b1);
    check("t4_clr", 128'(frame_err), 128'(0));

    // Long frame of 15 beats, then good frame
    fr.delete();
    for (int i = 0; i < 15; i++) fr.push_back(8'(8'h40 + i));
    send_list(fr, 1'b1, 0, 0, 0, 1'b0);
    idle(1, 1'b0);
    check("t5_err", 128'(frame_err), 128'(1));
    check("t5_cnt", 128'(frame_cnt), 128'(3));
    fr.delete();
    for (int i = 0; i < 12; i++) fr.push_back(8'(8'hC0 + i));
    send_list(fr, 1'b1, 0, 0, 20, 1'b0);
    idle(1, 1'b0);
    check("t5_m00", 128'(matrix00), 128'(8'hC0));

    // Clear while idle, then err_clr coinciding with short-frame in_last
    idle(1, 1'b1);
    fr.delete();
    for (int i = 0; i < 4; i++) fr.push_back(8'h55);
    send_list(fr, 1'b1, 0, 0, 0, 1'b1);
    idle(1, 1'b0);
    check("t6_set_wins", 128'(frame_err), 128'(1));

    // Reset mid-frame, then 0x10..0x1B
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(8'(8'h80 + i));
    send_list(fr, 1'b0, 0, 0, 0, 1'b0);
    do_reset();
    check("t7_zero", 128'(outs()), 128'(0));
    check("t7_cnt0", 128'(frame_cnt), 128'(0));
    fr.delete();
    for (int i = 0; i < 12; i++) fr.push_back(8'(8'h10 + i));
    send_list(fr, 1'b1, 0, 0, 0, 1'b0);
    idle(1, 1'b0);
    check("t7_m00", 128'(matrix00), 128'(8'h10));
    check("t7_cnt", 128'(frame_cnt), 128'(1));

    // Randomized frames of mixed length, gaps and clears
    for (int n = 0; n < 150; n++) begin
      int kind = $urandom_range(0, 9);
      int len  = 12;
      if (kind == 7) len = $urandom_range(1, 11);
      else if (kind == 8) len = $urandom_range(13, 16);
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      send_list(fr, 1'b1, 0, 0, 25, (kind == 9) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2), 1'($urandom));
    end

    idle(3, 1'b0);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
